// File: rtl/debounce_filter_pkg.sv
// debounce_filter_pkg: state encoding and default parameters shared by the debounce filter.
package debounce_filter_pkg;

   typedef enum logic [1:0] {
      ST_STABLE_LOW  = 2'd0,
      ST_WAIT_HIGH   = 2'd1,
      ST_STABLE_HIGH = 2'd2,
      ST_WAIT_LOW    = 2'd3
   } state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 4;

   function automatic state_t stable_state(input logic hi);
      return hi ? ST_STABLE_HIGH : ST_STABLE_LOW;
   endfunction

endpackage

// File: rtl/debounce_filter_sync_chain.sv
// sync_chain: N-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[N-2:0], d};
   end

   assign q = r_sync[N-1];

endmodule

// File: rtl/debounce_filter.sv
// debounce_filter: synchronises d_raw and releases a new level only after it has been stable
// for STABLE_CYCLES samples; aborted candidates are counted in a saturating glitch counter.
module debounce_filter
   import debounce_filter_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_W         = 8,
   parameter int GLITCH_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                d_raw,
   input  logic                glitch_clr,
   output logic                d_out,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   state_t              r_state, w_next;
   logic [CNT_W-1:0]    r_cnt, w_cnt_next;
   logic [GLITCH_W-1:0] r_glitch;
   logic                w_s, w_hi, w_wait, w_diff, w_done, w_glitch;

   sync_chain #(.N(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (d_raw),
      .q   (w_s)
   );

   assign w_hi     = (r_state == ST_STABLE_HIGH) || (r_state == ST_WAIT_LOW);
   assign w_wait   = (r_state == ST_WAIT_HIGH) || (r_state == ST_WAIT_LOW);
   assign w_diff   = w_s != w_hi;
   assign w_done   = w_wait ? (r_cnt == CNT_W'(STABLE_CYCLES - 1)) : (STABLE_CYCLES == 1);
   assign w_glitch = w_wait && !w_diff;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_STABLE_LOW;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // A sample matching the current level either holds a stable state or aborts a candidate.
   always_comb begin
      w_next     = !w_diff ? stable_state(w_hi) :
                   w_done  ? stable_state(!w_hi) :
                   (w_hi ? ST_WAIT_LOW : ST_WAIT_HIGH);
      w_cnt_next = (!w_diff || w_done) ? '0 : r_cnt + 1'b1;
   end

   always_comb begin
      d_out = w_hi;
      busy  = w_wait;
   end

   always_ff @(posedge clk) begin
      if (rst || glitch_clr)                  r_glitch <= '0;
      else if (w_glitch && (r_glitch != '1))  r_glitch <= r_glitch + 1'b1;
   end

   assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter: directed checks of debounce latency, bounce rejection, glitch counting and reset.
module tb_debounce_filter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       d_raw = 1'b0;
   logic       glitch_clr = 1'b0;
   logic       d_out, busy;
   logic [7:0] glitch_cnt;
   int         total = 0;
   int         bad = 0;
   int         n_busy, n_out;

   always #5 clk = ~clk;

   debounce_filter dut (
      .clk        (clk),
      .rst        (rst),
      .d_raw      (d_raw),
      .glitch_clr (glitch_clr),
      .d_out      (d_out),
      .busy       (busy),
      .glitch_cnt (glitch_cnt)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      d_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_dout", d_out, 0);
         check("rst_busy", busy, 0);
         check("rst_glitch", glitch_cnt, 0);
      end
      rst = 1'b0;
      tick(2);
      check("rel_busy_e2", busy, 0);
      tick();
      check("rel_busy_e3", busy, 1);
      tick(2);
      check("rel_dout_e5", d_out, 0);
      tick();
      check("rel_dout_e6", d_out, 1);
      check("rel_busy_e6", busy, 0);

      tick(20);
      d_raw = 1'b0;
      tick(2);
      check("fall_busy_e2", busy, 0);
      tick(3);
      check("fall_dout_e5", d_out, 1);
      tick();
      check("fall_dout_e6", d_out, 0);
      check("clean_glitch", glitch_cnt, 0);
      tick(10);

      d_raw = 1'b1; tick();
      d_raw = 1'b0; tick();
      d_raw = 1'b1; tick();
      d_raw = 1'b0; tick();
      d_raw = 1'b1;
      n_out = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_out += int'(d_out);
      end
      check("bounce_hold", n_out, 0);
      tick();
      check("bounce_dout_e6", d_out, 1);
      check("bounce_glitch", glitch_cnt, 2);
      d_raw = 1'b0;
      tick(10);
      check("bounce_fall", d_out, 0);
      glitch_clr = 1'b1;
      tick();
      glitch_clr = 1'b0;
      check("clr_plain", glitch_cnt, 0);

      d_raw = 1'b1;
      tick(3);
      d_raw = 1'b0;
      n_busy = 0;
      n_out  = 0;
      for (int i = 0; i < 10; i++) begin
         n_busy += int'(busy);
         n_out  += int'(d_out);
         tick();
      end
      check("pulse_busy_cycles", n_busy, 3);
      check("pulse_dout", n_out, 0);
      check("pulse_glitch", glitch_cnt, 1);

      for (int i = 0; i < 300; i++) begin
         d_raw = 1'b1; tick();
         d_raw = 1'b0; tick();
      end
      tick(4);
      check("sat_glitch", glitch_cnt, 255);
      check("sat_dout", d_out, 0);

      d_raw = 1'b1; tick();
      d_raw = 1'b0; tick(2);
      check("clrglitch_busy", busy, 1);
      glitch_clr = 1'b1;
      tick();
      glitch_clr = 1'b0;
      check("clrglitch_cnt", glitch_cnt, 0);
      check("clrglitch_busy_after", busy, 0);
      tick(3);
      check("clrglitch_stay", glitch_cnt, 0);

      d_raw = 1'b1;
      tick(4);
      check("midq_busy", busy, 1);
      rst = 1'b1;
      tick();
      check("midq_dout", d_out, 0);
      check("midq_busy_rst", busy, 0);
      check("midq_glitch", glitch_cnt, 0);
      rst = 1'b0;
      d_raw = 1'b0;
      tick(10);
      check("midq_idle_dout", d_out, 0);
      check("midq_idle_glitch", glitch_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
